// File: rtl/adc_seq_pkg.sv
// ============================================================================
// Module      : adc_seq_pkg
// Description : Shared state encoding, data width and timer sizing for the
//               ADC sample sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_seq_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_AMP_REQ     = 3'd1,
    S_AMP_WAIT    = 3'd2,
    S_CONV_REQ    = 3'd3,
    S_CONV_WAIT   = 3'd4,
    S_PERIOD_WAIT = 3'd5
  } seq_state_e;

  // Headroom of two covers the cycle spent in PERIOD_WAIT after a late Init_Done.
  function automatic int timer_width(input int sample_period, input int done_timeout);
    int m;
    m = (sample_period > done_timeout) ? sample_period : done_timeout;
    return $clog2(m + 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_cycle_timer.sv
// ============================================================================
// Module      : seq_cycle_timer
// Description : Saturating up-counter with load and a terminal-reached flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_term,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  // Greater-or-equal so an overshoot still terminates the wait.
  assign o_tc = (r_count >= i_term);

endmodule

`default_nettype wire

// File: rtl/adc_sample_sequencer.sv
// ============================================================================
// Module      : adc_sample_sequencer
// Description : Sequences amplifier-gain and ADC conversion requests to an SPI
//               segment and averages 2^AVG_LOG2 samples per result.
//               Optional min/max tracking under macro ADC_SEQ_MINMAX_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_sample_sequencer
  import adc_seq_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 5000,
  parameter int AVG_LOG2      = 3,
  parameter int DONE_TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Start,
  output logic              Init,
  output logic              AMP_ADC,
  input  logic              Init_Done,
  input  logic [DATA_W-1:0] Data,
  output logic [DATA_W-1:0] Sample_Avg,
  output logic              Avg_Valid,
  output logic              Busy,
`ifdef ADC_SEQ_MINMAX_EN
  output logic              Timeout_Err,
  output logic [DATA_W-1:0] Sample_Min,
  output logic [DATA_W-1:0] Sample_Max
`else
  output logic              Timeout_Err
`endif
);

  localparam int c_tw    = timer_width(SAMPLE_PERIOD, DONE_TIMEOUT);
  localparam int c_acc_w = DATA_W + AVG_LOG2;
  localparam int c_cnt_w = AVG_LOG2 + 1;
  localparam logic [c_cnt_w-1:0] c_last        = c_cnt_w'((1 << AVG_LOG2) - 1);
  localparam logic [c_tw-1:0]    c_period_term = c_tw'(SAMPLE_PERIOD - 1);
  localparam logic [c_tw-1:0]    c_done_term   = c_tw'(DONE_TIMEOUT);
  localparam logic [c_tw-1:0]    c_load_one    = c_tw'(1);

  seq_state_e          r_state;
  seq_state_e          w_next;
  logic                r_stop_req;
  logic                w_stop;
  logic                w_load;
  logic                w_en;
  logic [c_tw-1:0]     w_term;
  logic                w_tc;
  logic                w_capture;
  logic                w_timeout;
  logic [c_acc_w-1:0]  r_acc;
  logic [c_acc_w-1:0]  w_sum;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [DATA_W-1:0]   r_sample_avg;
  logic                r_avg_valid;
  logic                r_timeout_err;

  // A Start drop seen in any active state ends the run after the current transaction.
  assign w_stop = !Start || r_stop_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:        if (Start && !r_timeout_err) w_next = S_AMP_REQ;
      S_AMP_REQ:     w_next = S_AMP_WAIT;
      S_AMP_WAIT: begin
        if (Init_Done)  w_next = w_stop ? S_IDLE : S_CONV_REQ;
        else if (w_tc)  w_next = S_IDLE;
      end
      S_CONV_REQ:    w_next = S_CONV_WAIT;
      S_CONV_WAIT: begin
        if (Init_Done)  w_next = w_stop ? S_IDLE : S_PERIOD_WAIT;
        else if (w_tc)  w_next = S_IDLE;
      end
      S_PERIOD_WAIT: begin
        if (w_stop)     w_next = S_IDLE;
        else if (w_tc)  w_next = S_CONV_REQ;
      end
      default:       w_next = S_IDLE;
    endcase
  end

  always_comb begin
    Init      = (r_state == S_AMP_REQ) || (r_state == S_CONV_REQ);
    AMP_ADC   = (r_state == S_AMP_REQ) || (r_state == S_AMP_WAIT);
    Busy      = (r_state != S_IDLE);
    // The request cycle is cycle zero, so the first wait cycle reads one.
    w_load    = Init;
    w_en      = (r_state == S_AMP_WAIT) || (r_state == S_CONV_WAIT) ||
                (r_state == S_PERIOD_WAIT);
    w_term    = (r_state == S_PERIOD_WAIT) ? c_period_term : c_done_term;
    w_capture = (r_state == S_CONV_WAIT) && Init_Done && !w_stop;
    w_timeout = ((r_state == S_AMP_WAIT) || (r_state == S_CONV_WAIT)) &&
                !Init_Done && w_tc;
  end

  seq_cycle_timer #(
    .WIDTH (c_tw)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (c_load_one),
    .i_en       (w_en),
    .i_term     (w_term),
    .o_tc       (w_tc)
  );

  assign w_sum = r_acc + c_acc_w'(Data);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stop_req    <= 1'b0;
      r_acc         <= '0;
      r_cnt         <= '0;
      r_sample_avg  <= '0;
      r_avg_valid   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_avg_valid <= 1'b0;
      r_stop_req  <= (r_state == S_IDLE) ? 1'b0 : (r_stop_req || !Start);
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end else if (!Start) begin
        r_timeout_err <= 1'b0;
      end
      // Partial sums never survive a return to IDLE.
      if (r_state == S_IDLE) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_capture) begin
        if (r_cnt == c_last) begin
          r_sample_avg <= w_sum[AVG_LOG2 +: DATA_W];
          r_avg_valid  <= 1'b1;
          r_acc        <= '0;
          r_cnt        <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + c_cnt_w'(1);
        end
      end
    end
  end

  assign Sample_Avg  = r_sample_avg;
  assign Avg_Valid   = r_avg_valid;
  assign Timeout_Err = r_timeout_err;

`ifdef ADC_SEQ_MINMAX_EN
  logic              r_start_q;
  logic [DATA_W-1:0] r_min;
  logic [DATA_W-1:0] r_max;
  logic [DATA_W-1:0] w_min_base;
  logic [DATA_W-1:0] w_max_base;

  always_comb begin
    w_min_base = (Start && !r_start_q) ? {DATA_W{1'b1}} : r_min;
    w_max_base = (Start && !r_start_q) ? {DATA_W{1'b0}} : r_max;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_start_q <= 1'b0;
      r_min     <= {DATA_W{1'b1}};
      r_max     <= {DATA_W{1'b0}};
    end else begin
      r_start_q <= Start;
      r_min     <= (w_capture && (Data < w_min_base)) ? Data : w_min_base;
      r_max     <= (w_capture && (Data > w_max_base)) ? Data : w_max_base;
    end
  end

  assign Sample_Min = r_min;
  assign Sample_Max = r_max;
`endif

endmodule

`default_nettype wire

// File: tb/tb_adc_sample_sequencer.sv
// ============================================================================
// Module      : tb_adc_sample_sequencer
// Description : Directed self-checking bench; two sequencers share clk/rst,
//               dut0 averages 8 samples, dut1 averages 4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_sample_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start [2];
  logic       init_done [2];
  logic [7:0] data [2];
  logic       init [2];
  logic       amp_adc [2];
  logic [7:0] sample_avg [2];
  logic       avg_valid [2];
  logic       busy [2];
  logic       timeout_err [2];
`ifdef ADC_SEQ_MINMAX_EN
  logic [7:0] smin [2];
  logic [7:0] smax [2];
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int init_cnt [2] = '{0, 0};
  int avg_pulses [2] = '{0, 0};
  int exp_q0 [$];
  int exp_q1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  adc_sample_sequencer #(.SAMPLE_PERIOD(64), .AVG_LOG2(3), .DONE_TIMEOUT(16)) dut0 (
    .clk(clk), .rst(rst), .Start(start[0]), .Init(init[0]), .AMP_ADC(amp_adc[0]),
    .Init_Done(init_done[0]), .Data(data[0]), .Sample_Avg(sample_avg[0]),
    .Avg_Valid(avg_valid[0]), .Busy(busy[0]),
`ifdef ADC_SEQ_MINMAX_EN
    .Timeout_Err(timeout_err[0]), .Sample_Min(smin[0]), .Sample_Max(smax[0])
`else
    .Timeout_Err(timeout_err[0])
`endif
  );

  adc_sample_sequencer #(.SAMPLE_PERIOD(64), .AVG_LOG2(2), .DONE_TIMEOUT(16)) dut1 (
    .clk(clk), .rst(rst), .Start(start[1]), .Init(init[1]), .AMP_ADC(amp_adc[1]),
    .Init_Done(init_done[1]), .Data(data[1]), .Sample_Avg(sample_avg[1]),
    .Avg_Valid(avg_valid[1]), .Busy(busy[1]),
`ifdef ADC_SEQ_MINMAX_EN
    .Timeout_Err(timeout_err[1]), .Sample_Min(smin[1]), .Sample_Max(smax[1])
`else
    .Timeout_Err(timeout_err[1])
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_init(input int i, output int at);
    at = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (init[i] === 1'b1) begin
        at = cyc;
        break;
      end
    end
    check("init_seen", 32'(at >= 0), 1);
  endtask

  task automatic respond(input int i, input logic [7:0] d, input int delay);
    repeat (delay) @(negedge clk);
    init_done[i] = 1'b1;
    data[i]      = d;
    @(negedge clk);
    init_done[i] = 1'b0;
    data[i]      = 8'($urandom);
  endtask

  // Scoreboard consumer: every Avg_Valid pops one expected average.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (init[i] === 1'b1) init_cnt[i]++;
      if (avg_valid[i] === 1'b1) begin
        int e;
        e = -1;
        avg_pulses[i]++;
        if (i == 0 && exp_q0.size() > 0) e = exp_q0.pop_front();
        if (i == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
        check("avg_scoreboard", 32'(sample_avg[i]), e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int at, prev, sum, snap;
    logic [7:0] tv [4];
    logic [7:0] mm [3];
    tv = '{8'd255, 8'd255, 8'd255, 8'd254};
    mm = '{8'd7, 8'd200, 8'd3};
    start = '{1'b0, 1'b0};
    init_done = '{1'b0, 1'b0};
    data = '{8'd0, 8'd0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_init", 32'(init[0]), 0);
    check("rst_amp", 32'(amp_adc[0]), 0);
    check("rst_busy", 32'(busy[0]), 0);
    check("rst_avg", 32'(sample_avg[0]), 0);
    check("rst_valid", 32'(avg_valid[0]), 0);
    check("rst_err", 32'(timeout_err[0]), 0);
`ifdef ADC_SEQ_MINMAX_EN
    check("rst_min", 32'(smin[0]), 32'hFF);
    check("rst_max", 32'(smax[0]), 32'h00);
`endif
    rst = 1'b1;
    @(negedge clk);

    // Startup: gain transaction first, conversion request right after Init_Done
    start[0] = 1'b1;
    wait_init(0, at);
    check("start_amp", 32'(amp_adc[0]), 1);
    respond(0, 8'h00, 3);
    check("conv_init", 32'(init[0]), 1);
    check("conv_amp", 32'(amp_adc[0]), 0);
    prev = cyc;

    // Averaging 10..80 over 8 samples
    sum = 0;
    for (int k = 0; k < 8; k++) sum += 10 * (k + 1);
    exp_q0.push_back(sum >> 3);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        wait_init(0, at);
        check("init_spacing", 32'(at - prev), 64);
        prev = at;
      end
      respond(0, 8'(10 * (k + 1)), 2);
    end
    check("avg_valid_hi", 32'(avg_valid[0]), 1);
    check("avg_45", 32'(sample_avg[0]), 45);
    start[0] = 1'b0;
    @(negedge clk);
    check("avg_valid_lo", 32'(avg_valid[0]), 0);
    check("avg_pulses", 32'(avg_pulses[0]), 1);
    check("stop_idle", 32'(busy[0]), 0);
    check("avg_hold", 32'(sample_avg[0]), 45);

    // Timeout with Init_Done withheld
    start[0] = 1'b1;
    wait_init(0, at);
    check("to_amp", 32'(amp_adc[0]), 1);
    repeat (16) @(negedge clk);
    check("to_err_pre", 32'(timeout_err[0]), 0);
    check("to_busy_pre", 32'(busy[0]), 1);
    @(negedge clk);
    check("to_err_set", 32'(timeout_err[0]), 1);
    check("to_idle", 32'(busy[0]), 0);
    snap = init_cnt[0];
    repeat (20) @(negedge clk);
    check("to_no_init", 32'(init_cnt[0]), 32'(snap));
    check("to_sticky", 32'(timeout_err[0]), 1);
    start[0] = 1'b0;
    @(negedge clk);
    check("to_clear", 32'(timeout_err[0]), 0);
    start[0] = 1'b1;
    wait_init(0, at);
    check("restart_amp", 32'(amp_adc[0]), 1);

    // Asynchronous reset during CONV_WAIT
    respond(0, 8'h00, 3);
    check("rc_conv_init", 32'(init[0]), 1);
    @(negedge clk);
    check("rc_in_wait", 32'(busy[0]), 1);
    #2 rst = 1'b0;
    #1;
    check("ar_init", 32'(init[0]), 0);
    check("ar_amp", 32'(amp_adc[0]), 0);
    check("ar_busy", 32'(busy[0]), 0);
    check("ar_avg", 32'(sample_avg[0]), 0);
    check("ar_valid", 32'(avg_valid[0]), 0);
    check("ar_err", 32'(timeout_err[0]), 0);
    @(negedge clk);
    rst = 1'b1;
    wait_init(0, at);
    check("ar_first_amp", 32'(amp_adc[0]), 1);

    // Three captures 7,200,3 then Start drop (min/max when built in)
    respond(0, 8'h00, 2);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) wait_init(0, at);
      respond(0, mm[k], 2);
    end
`ifdef ADC_SEQ_MINMAX_EN
    check("minmax_min", 32'(smin[0]), 3);
    check("minmax_max", 32'(smax[0]), 200);
`endif
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("partial_idle", 32'(busy[0]), 0);
    check("partial_no_avg", 32'(sample_avg[0]), 0);

    // Truncation on dut1: 255,255,255,254 over 4 samples
    start[1] = 1'b1;
    wait_init(1, at);
    check("d1_amp", 32'(amp_adc[1]), 1);
    respond(1, 8'h11, 2);
    check("d1_conv_init", 32'(init[1]), 1);
    sum = 0;
    for (int k = 0; k < 4; k++) sum += int'(tv[k]);
    exp_q1.push_back(sum >> 2);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) wait_init(1, at);
      respond(1, tv[k], 2);
    end
    check("d1_valid", 32'(avg_valid[1]), 1);
    check("d1_avg_254", 32'(sample_avg[1]), 254);
    start[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("sb_empty", 32'(exp_q0.size() + exp_q1.size()), 0);
    check("d1_pulses", 32'(avg_pulses[1]), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
